// File: rtl/inst_encoder.sv
// inst_encoder: two-stage RV32I instruction encoder.
// S1 captures the field set, its opcode and (optionally) a range check.
// S2 holds the packed instruction word, its write address and the error flag.
// Optional feature: define IMM_CHECK_EN to flag out-of-range immediates on
// out_err/err_seen. Without it both are tied low and fields are truncated.

module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_seen
);

    typedef enum logic [2:0] {
        K_IALU   = 3'd0,
        K_LOAD   = 3'd1,
        K_JALR   = 3'd2,
        K_STORE  = 3'd3,
        K_JAL    = 3'd4,
        K_LUI    = 3'd5,
        K_AUIPC  = 3'd6,
        K_BRANCH = 3'd7
    } kind_e;

    kind_e       in_kind_e;
    logic [6:0]  in_op;
    logic [2:0]  in_f3_eff;
    logic        s2_take;

    logic        s1_valid;
    kind_e       s1_kind;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic        s1_f7b5;
    logic [31:0] s1_imm;
    logic [31:0] packed_word;

    assign in_kind_e = kind_e'(in_kind);
    assign s2_take   = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_take;

    // Map the instruction class onto its major opcode; JALR always carries funct3=000.
    always_comb begin
        in_op     = 7'b0010011;
        in_f3_eff = in_funct3;
        case (in_kind_e)
            K_IALU:   in_op = 7'b0010011;
            K_LOAD:   in_op = 7'b0000011;
            K_JALR: begin
                in_op     = 7'b1100111;
                in_f3_eff = 3'b000;
            end
            K_STORE:  in_op = 7'b0100011;
            K_JAL:    in_op = 7'b1101111;
            K_LUI:    in_op = 7'b0110111;
            K_AUIPC:  in_op = 7'b0010111;
            K_BRANCH: in_op = 7'b1100011;
            default:  in_op = 7'b0010011;
        endcase
    end

    // Stage 1: capture the field set whenever the stage can accept a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_kind  <= K_IALU;
            s1_op    <= 7'd0;
            s1_rd    <= 5'd0;
            s1_rs1   <= 5'd0;
            s1_rs2   <= 5'd0;
            s1_f3    <= 3'd0;
            s1_f7b5  <= 1'b0;
            s1_imm   <= 32'd0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_kind <= in_kind_e;
                s1_op   <= in_op;
                s1_rd   <= in_rd;
                s1_rs1  <= in_rs1;
                s1_rs2  <= in_rs2;
                s1_f3   <= in_f3_eff;
                s1_f7b5 <= in_f7b5;
                s1_imm  <= in_imm;
            end
        end
    end

    // Scatter the immediate bits into the format of the captured instruction class.
    always_comb begin
        packed_word = 32'd0;
        case (s1_kind)
            K_IALU: begin
                if (s1_f3 == 3'b001 || s1_f3 == 3'b101)
                    packed_word = {1'b0, s1_f7b5, 5'b00000, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_op};
                else
                    packed_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            end
            K_LOAD, K_JALR:
                packed_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            K_STORE:
                packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
            K_BRANCH:
                packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                               s1_imm[4:1], s1_imm[11], s1_op};
            K_JAL:
                packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
            K_LUI, K_AUIPC:
                packed_word = {s1_imm[31:12], s1_rd, s1_op};
            default:
                packed_word = 32'd0;
        endcase
    end

    // Stage 2: load the packed word when the output slot frees up; the address
    // counter doubles as the tag for the word in (or next entering) the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_addr  <= BASE_ADDR[ADDR_W-1:0];
        end else begin
            if (out_valid && out_ready)
                out_addr <= out_addr + ADDR_W'(4);
            if (s2_take) begin
                out_valid <= s1_valid;
                if (s1_valid)
                    out_inst <= packed_word;
            end
        end
    end

`ifdef IMM_CHECK_EN
    logic in_err;
    logic s1_err;
    logic is_shift;

    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // Range check of the raw immediate against what the target format can hold.
    always_comb begin
        in_err = 1'b0;
        case (in_kind_e)
            K_IALU: begin
                if (is_shift)
                    in_err = ($signed(in_imm) < 32'sd0) || ($signed(in_imm) > 32'sd31);
                else
                    in_err = ($signed(in_imm) < -32'sd2048) || ($signed(in_imm) > 32'sd2047);
            end
            K_LOAD, K_JALR, K_STORE:
                in_err = ($signed(in_imm) < -32'sd2048) || ($signed(in_imm) > 32'sd2047);
            K_BRANCH:
                in_err = ($signed(in_imm) < -32'sd4096) || ($signed(in_imm) > 32'sd4094) || in_imm[0];
            K_JAL:
                in_err = ($signed(in_imm) < -32'sd1048576) || ($signed(in_imm) > 32'sd1048574)
                         || in_imm[0];
            K_LUI, K_AUIPC:
                in_err = (in_imm[11:0] != 12'd0);
            default:
                in_err = 1'b0;
        endcase
    end

    // Error flag travels alongside its word; err_seen latches any flagged handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err   <= 1'b0;
            out_err  <= 1'b0;
            err_seen <= 1'b0;
        end else begin
            if (in_ready && in_valid)
                s1_err <= in_err;
            if (s2_take && s1_valid)
                out_err <= s1_err;
            if (out_valid && out_ready && out_err)
                err_seen <= 1'b1;
        end
    end
`else
    assign out_err  = 1'b0;
    assign err_seen = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed bench for inst_encoder with a second, narrow-address
// instance (ADDR_W=4, BASE_ADDR=12) sharing the same stimulus to show wrap-around.

module tb_inst_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic        in_f7b5;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_seen;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_out_inst;
    logic [3:0]  w_out_addr;
    logic        w_out_err;
    logic        w_err_seen;

    int compared;
    int mismatched;

`ifdef IMM_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    inst_encoder #(.BASE_ADDR(32'h0000_0000), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .out_err(out_err), .err_seen(err_seen)
    );

    inst_encoder #(.BASE_ADDR(32'd12), .ADDR_W(4)) u_wrap (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_inst(w_out_inst), .out_addr(w_out_addr),
        .out_err(w_out_err), .err_seen(w_err_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one field set on the input port (held until the caller changes it).
    task automatic applyStimulus(input logic [2:0] kind, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic f7b5,
                                 input logic [31:0] imm);
        in_valid  = 1'b1;
        in_kind   = kind;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_f7b5   = f7b5;
        in_imm    = imm;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        out_ready  = 1'b1;
        applyStimulus(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
        in_valid   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_inst",  out_inst, 32'd0);
        checkOutput("rst_out_addr",  out_addr, 32'd0);
        checkOutput("rst_err_seen",  {31'd0, err_seen}, 32'd0);
        checkOutput("rst_wrap_addr", {28'd0, w_out_addr}, 32'd12);

        // ADDI x1, x0, -1 with two-cycle latency
        applyStimulus(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        checkOutput("addi_lat1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("addi_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("addi_inst",  out_inst, 32'hFFF00093);
        checkOutput("addi_addr",  out_addr, 32'h0);
        checkOutput("addi_err",   {31'd0, out_err}, 32'd0);
        checkOutput("addi_wrap_addr", {28'd0, w_out_addr}, 32'd12);

        // Back-to-back SW, JAL, BEQ with out_ready held high
        applyStimulus(3'd3, 5'd0, 5'd3, 5'd2, 3'b010, 1'b0, 32'd8);
        tick();
        applyStimulus(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
        tick();
        checkOutput("sw_inst", out_inst, 32'h0021A423);
        checkOutput("sw_addr", out_addr, 32'h4);
        checkOutput("sw_wrap_addr", {28'd0, w_out_addr}, 32'd0);
        applyStimulus(3'd7, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);
        tick();
        checkOutput("jal_inst", out_inst, 32'h001000EF);
        checkOutput("jal_addr", out_addr, 32'h8);
        in_valid = 1'b0;
        tick();
        checkOutput("beq_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("beq_inst",  out_inst, 32'hFE208EE3);
        checkOutput("beq_addr",  out_addr, 32'hC);
        tick();
        checkOutput("b2b_drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: three ADDIs offered while out_ready is low
        out_ready = 1'b0;
        applyStimulus(3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
        checkOutput("bp_ready_a", {31'd0, in_ready}, 32'd1);
        tick();
        applyStimulus(3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2);
        checkOutput("bp_ready_b", {31'd0, in_ready}, 32'd1);
        tick();
        applyStimulus(3'd0, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
        checkOutput("bp_ready_c", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_hold_inst", out_inst, 32'h00100113);
        checkOutput("bp_hold_addr", out_addr, 32'h10);
        tick();
        checkOutput("bp_stall_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_stall_inst",  out_inst, 32'h00100113);
        checkOutput("bp_stall_addr",  out_addr, 32'h10);
        checkOutput("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("bp_b_inst", out_inst, 32'h00200193);
        checkOutput("bp_b_addr", out_addr, 32'h14);
        tick();
        checkOutput("bp_c_inst", out_inst, 32'h00300213);
        checkOutput("bp_c_addr", out_addr, 32'h18);
        tick();
        checkOutput("bp_drain_valid", {31'd0, out_valid}, 32'd0);

        // ADDI with out-of-range imm=2048
        applyStimulus(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("big_inst", out_inst, 32'h80000093);
        checkOutput("big_addr", out_addr, 32'h1C);
        checkOutput("big_err",  {31'd0, out_err}, {31'd0, ERR_EXP});
        tick();
        checkOutput("big_seen", {31'd0, err_seen}, {31'd0, ERR_EXP});

        // LUI, SRAI and JALR (funct3 forced to 000) back-to-back
        applyStimulus(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
        tick();
        applyStimulus(3'd0, 5'd1, 5'd1, 5'd0, 3'b101, 1'b1, 32'd3);
        tick();
        checkOutput("lui_inst", out_inst, 32'h123452B7);
        checkOutput("lui_addr", out_addr, 32'h20);
        checkOutput("lui_err",  {31'd0, out_err}, 32'd0);
        applyStimulus(3'd2, 5'd1, 5'd5, 5'd0, 3'b111, 1'b0, 32'd4);
        tick();
        in_valid = 1'b0;
        checkOutput("srai_inst", out_inst, 32'h4030D093);
        checkOutput("srai_addr", out_addr, 32'h24);
        tick();
        checkOutput("jalr_inst", out_inst, 32'h004280E7);
        checkOutput("jalr_addr", out_addr, 32'h28);
        checkOutput("seen_sticky", {31'd0, err_seen}, {31'd0, ERR_EXP});
        tick();

        // Reset with two words in flight
        out_ready = 1'b0;
        applyStimulus(3'd0, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'd6);
        tick();
        applyStimulus(3'd0, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7);
        tick();
        checkOutput("mid_prefill_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid_rst_seen",  {31'd0, err_seen}, 32'd0);
        checkOutput("mid_rst_addr",  out_addr, 32'h0);
        checkOutput("mid_rst_inst",  out_inst, 32'h0);
        applyStimulus(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("post_rst_inst", out_inst, 32'hFFF00093);
        checkOutput("post_rst_addr", out_addr, 32'h0);
        checkOutput("post_rst_wrap_addr", {28'd0, w_out_addr}, 32'd12);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
